run_trace_ctrl: RTL

Synthesizable run controller and instruction-trace recorder for the CU/DataPath core. It sequences core reset, gates core execution with a clock-enable, and stops on a cycle limit or PC breakpoint. Every fetched {PC, IR} pair is captured into a circular trace buffer that can be read back while halted. It sits beside the CU, between the board-level start/debug controls and the core's Reset and enable inputs.

---
 rtl/run_trace_pkg.sv | 26 ++
 rtl/run_trace_ctrl_trace_ram.sv | 33 +++
 rtl/run_trace_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/run_trace_pkg.sv
// Shared types for the run controller: FSM states and halt-cause codes.
package run_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RST_HOLD = 2'd1,
      ST_RUN      = 2'd2,
      ST_HALT     = 2'd3
   } state_e;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_LIMIT = 2'd1;
   localparam logic [1:0] CAUSE_BREAK = 2'd2;
   localparam logic [1:0] CAUSE_BOTH  = 2'd3;

   // Combine the two halt sources into one cause code.
   function automatic logic [1:0] halt_cause_of(input logic brk, input logic lim);
      logic [1:0] c;
      c = CAUSE_NONE;
      if (brk && lim) c = CAUSE_BOTH;
      else if (brk)   c = CAUSE_BREAK;
      else if (lim)   c = CAUSE_LIMIT;
      return c;
   endfunction

endpackage

// File: rtl/run_trace_ctrl_trace_ram.sv
// Trace storage: one synchronous write port, one registered read port.
// The array itself has no reset; only the read register is cleared.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write the captured entry into the array.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Registered read; a disabled read returns zero (index beyond valid entries).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rdata_q <= '0;
      else          rdata_q <= re_i ? mem_q[raddr_i] : '0;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/run_trace_ctrl.sv
// Run controller and instruction-trace recorder for the CU/DataPath core.
// Sequences core reset, gates execution with core_run, halts on a cycle
// limit or PC breakpoint, and records every fetched {PC, IR} pair.
// start/resume are single-cycle pulses sampled on the rising edge; start
// always wins over resume and over halt events in the same cycle.
module run_trace_ctrl
   import run_trace_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int TRACE_DEPTH = 16,
   parameter int CYC_W       = 16,
   parameter int NUM_BP      = 2,
   parameter int RST_CYCLES  = 4
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           start,
   input  logic                           resume,
   input  logic [CYC_W-1:0]               cycle_limit,
   input  logic [NUM_BP-1:0]              bp_en,
   input  logic [NUM_BP*DATA_W-1:0]       bp_addr,
   input  logic                           fetch_valid,
   input  logic [DATA_W-1:0]              PC,
   input  logic [DATA_W-1:0]              IR,
   output logic                           core_reset_n,
   output logic                           core_run,
   output logic                           halted,
   output logic [1:0]                     halt_cause,
   output logic [CYC_W-1:0]               cycle_count,
   output logic [$clog2(TRACE_DEPTH):0]   trace_count,
   output logic                           trace_ovf,
   input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
   output logic [2*DATA_W-1:0]            rd_data,
   output state_e                         dbg_state
);

   localparam int AW  = $clog2(TRACE_DEPTH);
   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0]   RST_LAST  = RCW'(RST_CYCLES - 1);
   localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(TRACE_DEPTH);
   localparam logic [CYC_W-1:0] CYC_MAX   = '1;

   state_e           state_q, state_d;
   logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [1:0]       cause_q, cause_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      tcnt_q, tcnt_d;
   logic             ovf_q, ovf_d;
   logic             skip_q, skip_d;
   logic             reset_n_q, reset_n_d;
   logic             run_q, run_d;
   logic             halted_q, halted_d;

   logic [NUM_BP-1:0] bp_hit;
   logic [CYC_W-1:0]  cyc_inc;
   logic              brk_evt;
   logic              lim_evt;
   logic              limit_reached;
   logic              ram_we;
   logic [AW-1:0]     rd_phys;
   logic              rd_ok;

   // One address comparator per breakpoint slot.
   for (genvar k = 0; k < NUM_BP; k++) begin : g_bp
      assign bp_hit[k] = bp_en[k] && (PC == bp_addr[k*DATA_W +: DATA_W]);
   end

   assign cyc_inc       = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_W'(1);
   // The first RUN cycle after a resume may present the PC that just broke.
   assign brk_evt       = fetch_valid && (|bp_hit) && !skip_q;
   assign lim_evt       = (cycle_limit != '0) && (cyc_inc == cycle_limit);
   assign limit_reached = (cycle_limit != '0) && (cyc_q >= cycle_limit);

   // Index 0 is the oldest valid entry; wrap is implicit in AW-bit arithmetic.
   assign rd_phys = wr_ptr_q - tcnt_q[AW-1:0] + rd_idx;
   assign rd_ok   = ({1'b0, rd_idx} < tcnt_q);

   // Next-state, counters, trace bookkeeping and registered-output values.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cyc_d     = cyc_q;
      cause_d   = cause_q;
      wr_ptr_d  = wr_ptr_q;
      tcnt_d    = tcnt_q;
      ovf_d     = ovf_q;
      skip_d    = skip_q;
      ram_we    = 1'b0;

      if (start) begin
         state_d   = ST_RST_HOLD;
         rst_cnt_d = '0;
         cyc_d     = '0;
         cause_d   = CAUSE_NONE;
         wr_ptr_d  = '0;
         tcnt_d    = '0;
         ovf_d     = 1'b0;
         skip_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_RST_HOLD: begin
               if (rst_cnt_q == RST_LAST) state_d = ST_RUN;
               else                       rst_cnt_d = rst_cnt_q + RCW'(1);
            end
            ST_RUN: begin
               cyc_d  = cyc_inc;
               skip_d = 1'b0;
               if (fetch_valid) begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  if (tcnt_q == DEPTH_CNT) ovf_d  = 1'b1;
                  else                     tcnt_d = tcnt_q + (AW+1)'(1);
               end
               if (brk_evt || lim_evt) begin
                  state_d = ST_HALT;
                  cause_d = halt_cause_of(brk_evt, lim_evt);
               end
            end
            ST_HALT: begin
               if (resume && !limit_reached) begin
                  state_d = ST_RUN;
                  cause_d = CAUSE_NONE;
                  skip_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      reset_n_d = (state_d == ST_RUN) || (state_d == ST_HALT);
      run_d     = (state_d == ST_RUN);
      halted_d  = (state_d == ST_HALT);
   end

   // State and status registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_IDLE;
         rst_cnt_q <= '0;
         cyc_q     <= '0;
         cause_q   <= CAUSE_NONE;
         wr_ptr_q  <= '0;
         tcnt_q    <= '0;
         ovf_q     <= 1'b0;
         skip_q    <= 1'b0;
         reset_n_q <= 1'b0;
         run_q     <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cyc_q     <= cyc_d;
         cause_q   <= cause_d;
         wr_ptr_q  <= wr_ptr_d;
         tcnt_q    <= tcnt_d;
         ovf_q     <= ovf_d;
         skip_q    <= skip_d;
         reset_n_q <= reset_n_d;
         run_q     <= run_d;
         halted_q  <= halted_d;
      end
   end

   trace_ram #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (2*DATA_W)
   ) u_trace_ram (
      .clk_i   (Clk),
      .rst_n_i (Reset),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i ({PC, IR}),
      .re_i    (rd_ok),
      .raddr_i (rd_phys),
      .rdata_o (rd_data)
   );

   assign core_reset_n = reset_n_q;
   assign core_run     = run_q;
   assign halted       = halted_q;
   assign halt_cause   = cause_q;
   assign cycle_count  = cyc_q;
   assign trace_count  = tcnt_q;
   assign trace_ovf    = ovf_q;
   assign dbg_state    = state_q;

endmodule
